// File: rtl/fir_out_decim.sv
// fir_out_decim: output stage of the FIR filter.
// Integrates DECIM signed 18-bit samples, then rounds, scales and saturates
// each sum to a signed 8-bit word. Each word is pushed into a small FIFO.
// The filter cannot be stalled, so a word that finds the FIFO full is dropped
// and the sticky overflow flag is set.
module fir_out_decim #(
  parameter int DECIM = 4,   // samples per output word, 1..16
  parameter int SHIFT = 2,   // arithmetic right shift of the sum, 0..21
  parameter int DEPTH = 4    // FIFO depth, power of two, 2..16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic signed [17:0]             in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [7:0]              out_data,
  output logic [$clog2(DEPTH+1)-1:0]     level,
  output logic                           overflow
);

  localparam int AW = 22;                  // 18-bit samples plus 4 growth bits
  localparam int CW = 5;                   // holds 0..15 for any legal DECIM
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  localparam logic [CW-1:0]        CNT_LAST = CW'(DECIM-1);
  localparam logic [LW-1:0]        LVL_FULL = LW'(DEPTH);
  // One extra bit keeps the rounding add from wrapping at the extreme sum.
  localparam logic signed [AW:0]   RND      = (SHIFT > 0) ?
                                              (23'sd1 <<< ((SHIFT > 0) ? SHIFT-1 : 0)) : 23'sd0;
  localparam logic signed [AW:0]   SAT_HI   = 23'sd127;
  localparam logic signed [AW:0]   SAT_LO   = -23'sd128;

  // accumulator / dump path
  logic [CW-1:0]          cnt;
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   in_ext;
  logic signed [AW-1:0]   sum;
  logic signed [AW:0]     rnd_sum;
  logic signed [AW:0]     shifted;
  logic signed [7:0]      sat;
  logic signed [7:0]      res_q;
  logic                   res_vld;
  logic                   last;

  // FIFO
  logic [7:0]             mem [DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [LW-1:0]          lvl_q;
  logic                   full;
  logic                   push;
  logic                   pop;

  // Running sum including the current sample; count 0 restarts the group,
  // which also covers DECIM=1 where every sample is both first and last.
  always_comb begin
    in_ext  = {{(AW-18){in_data[17]}}, in_data};
    sum     = in_ext;
    if (cnt != '0) sum = acc + in_ext;
    last    = in_valid && (cnt == CNT_LAST);
    rnd_sum = {sum[AW-1], sum} + RND;
    shifted = rnd_sum >>> SHIFT;
    sat     = shifted[7:0];
    if (shifted > SAT_HI)      sat = 8'sd127;
    else if (shifted < SAT_LO) sat = -8'sd128;
  end

  // Sample counter, accumulator and the registered dump result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc     <= '0;
      res_q   <= '0;
      res_vld <= 1'b0;
    end else begin
      res_vld <= last;
      if (in_valid) begin
        acc <= sum;
        if (cnt == CNT_LAST) cnt <= '0;
        else                 cnt <= cnt + 1'b1;
      end
      if (last) res_q <= sat;
    end
  end

  // A push into a full FIFO is still taken if the head leaves the same cycle.
  always_comb begin
    full = (lvl_q == LVL_FULL);
    pop  = (lvl_q != '0) && out_ready;
    push = res_vld && (!full || pop);
  end

  // Storage has no reset; the empty gate on out_data hides stale entries.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= res_q;
  end

  // Pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      lvl_q    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   lvl_q <= lvl_q + 1'b1;
        2'b01:   lvl_q <= lvl_q - 1'b1;
        default: lvl_q <= lvl_q;
      endcase
      if (res_vld && !push) overflow <= 1'b1;
    end
  end

  // Head word presented combinationally, forced to 0 when empty.
  always_comb begin
    out_valid = (lvl_q != '0);
    out_data  = out_valid ? $signed(mem[rd_ptr]) : 8'sd0;
    level     = lvl_q;
  end

endmodule

// File: tb/tb_fir_out_decim.sv
// Bench for fir_out_decim with default parameters (DECIM=4, SHIFT=2, DEPTH=4).
// Stimulus pushes hand-computed words into a queue; a monitor pops and compares
// on every accepted output word.
module tb_fir_out_decim;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [17:0] in_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [7:0]  out_data;
  logic [2:0]         level;
  logic               overflow;

  int checks = 0;
  int failures = 0;
  logic signed [7:0] expq[$];

  fir_out_decim #(.DECIM(4), .SHIFT(2), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // monitor: every accepted word must match the queue head
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL word: got %0d, expected no word", out_data);
      end else begin
        logic signed [7:0] e;
        e = expq.pop_front();
        if (out_data !== e) begin
          failures++;
          $display("FAIL word: got %0d, expected %0d", out_data, e);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d);
    in_valid = 1'b1;
    in_data  = 18'(d);
    tick();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic group(input int a, input int b, input int c, input int d);
    send(a); send(b); send(c); send(d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_overflow", int'(overflow), 0);
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (level != 0 && n < 50) begin
      tick();
      n++;
    end
    chk(name, int'(level), 0);
  endtask

  initial begin
    // power-up reset
    #2;
    chk("por_out_valid", int'(out_valid), 0);
    chk("por_out_data", int'(out_data), 0);
    chk("por_overflow", int'(overflow), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: basic dump, 12 -> (12+2)>>2 = 3, visible 2 cycles after last sample
    out_ready = 1'b1;
    expq.push_back(8'sd3);
    group(12, 0, 0, 0);
    chk("s1_valid_early", int'(out_valid), 0);
    tick();
    chk("s1_valid", int'(out_valid), 1);
    chk("s1_data", int'(out_data), 3);
    tick();
    chk("s1_level", int'(level), 0);
    chk("s1_data_empty", int'(out_data), 0);

    // 2: gapped input and rounding
    expq.push_back(8'sd100);
    send(100); tick(); send(100); tick(); tick(); send(100); tick(); send(100);
    tick(); tick();
    expq.push_back(-8'sd1);
    group(-6, 0, 0, 0);
    tick(); tick();
    expq.push_back(8'sd1);
    group(2, 0, 0, 0);
    tick(); tick();
    wait_empty("s2_level");

    // 3: saturation
    expq.push_back(8'sd127);
    group(131071, 131071, 131071, 131071);
    expq.push_back(-8'sd128);
    group(-131072, -131072, -131072, -131072);
    tick(); tick();
    wait_empty("s3_level");

    // 4: fill, drop the fifth word, drain in order
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) expq.push_back(8'(k));
      group(4*k, 0, 0, 0);
    end
    tick(); tick(); tick();
    chk("s4_level_full", int'(level), 4);
    chk("s4_overflow", int'(overflow), 1);
    chk("s4_head", int'(out_data), 1);
    out_ready = 1'b1;
    wait_empty("s4_drain");
    chk("s4_overflow_sticky", int'(overflow), 1);
    out_ready = 1'b0;

    // 5: push and pop together at full
    do_reset();
    chk("s5_overflow_cleared", int'(overflow), 0);
    expq.push_back(8'sd10); expq.push_back(8'sd11);
    expq.push_back(8'sd12); expq.push_back(8'sd13);
    group(40, 0, 0, 0); group(44, 0, 0, 0);
    group(48, 0, 0, 0); group(52, 0, 0, 0);
    tick(); tick();
    chk("s5_level_full", int'(level), 4);
    expq.push_back(8'sd14);
    group(56, 0, 0, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("s5_level_kept", int'(level), 4);
    chk("s5_no_overflow", int'(overflow), 0);
    chk("s5_head", int'(out_data), 11);
    out_ready = 1'b1;
    wait_empty("s5_drain");

    // 6: reset mid-accumulation discards the partial sum
    send(40); send(40);
    do_reset();
    expq.push_back(8'sd4);
    group(4, 4, 4, 4);
    tick();
    chk("s6_valid", int'(out_valid), 1);
    chk("s6_data", int'(out_data), 4);
    tick();
    wait_empty("s6_level");

    tick(); tick();
    chk("queue_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // safety net against a stuck run
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
